// File: rtl/bsg_normalize_pkg.sv
// Shared definitions for the normalize-shift pipeline: sizing helper for the
// leading-zero count.
package bsg_normalize_pkg;

    // A count of 0..w leading zeros needs $clog2(w+1) bits.
    function automatic int lz_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bsg_counting_leading_zeros.sv
// Combinational leading-zero counter; an all-zero input reports width_p.
module bsg_counting_leading_zeros
    import bsg_normalize_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0]                i_data,
    output logic [lz_width(width_p)-1:0]      o_lz
);

    localparam int LZ_W = lz_width(width_p);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        o_lz = LZ_W'(width_p);
        for (int i = 0; i < width_p; i++) begin
            if (i_data[i]) begin
                o_lz = LZ_W'(width_p - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bsg_normalize_shift_pipe.sv
// Two-stage normalizer: S1 captures significand, exponent and leading-zero
// count; S2 holds the shifted significand and adjusted exponent.
module bsg_normalize_shift_pipe
    import bsg_normalize_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int exp_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    input  logic [exp_width_p-1:0] exp_i,
    output logic                   v_o,
    input  logic                   yumi_i,
    output logic [width_p-1:0]     data_o,
    output logic [exp_width_p-1:0] exp_o,
    output logic                   zero_o,
    output logic                   denorm_o
);

    localparam int LZ_W = lz_width(width_p);

    typedef struct packed {
        logic [width_p-1:0]     data;
        logic [exp_width_p-1:0] exp;
        logic                   zero;
        logic                   denorm;
    } s2_payload_t;

    function automatic logic [exp_width_p-1:0] sat_exp_sub(
        input logic [exp_width_p-1:0] a,
        input logic [exp_width_p-1:0] b
    );
        return (a >= b) ? (a - b) : '0;
    endfunction

    logic                   r_vld_p1;
    logic [width_p-1:0]     r_data_p1;
    logic [exp_width_p-1:0] r_exp_p1;
    logic [LZ_W-1:0]        r_lz_p1;
    logic                   r_vld_p2;
    s2_payload_t            r_pay_p2;

    logic                   w_adv1;
    logic                   w_adv2;
    logic [LZ_W-1:0]        w_lz_p0;
    logic [exp_width_p-1:0] w_lz_ext;
    logic [exp_width_p-1:0] w_sh;
    s2_payload_t            w_pay_p1;

    assign w_adv2  = r_vld_p1 & (~r_vld_p2 | yumi_i);
    assign w_adv1  = ~r_vld_p1 | w_adv2;
    assign ready_o = w_adv1;

    bsg_counting_leading_zeros #(.width_p(width_p)) u_clz (
        .i_data (data_i),
        .o_lz   (w_lz_p0)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_vld_p1 <= v_i;
            end
            if (w_adv2) begin
                r_vld_p2 <= 1'b1;
            end else if (yumi_i) begin
                r_vld_p2 <= 1'b0;
            end
        end
    end

    // S0 -> S1: capture input with its leading-zero count
    always_ff @(posedge clk_i) begin
        if (w_adv1 && v_i) begin
            r_data_p1 <= data_i;
            r_exp_p1  <= exp_i;
            r_lz_p1   <= w_lz_p0;
        end
    end

    // S1 -> S2: shift is capped by the exponent so it never goes below zero
    always_comb begin
        w_lz_ext = exp_width_p'(r_lz_p1);
        w_sh     = (w_lz_ext <= r_exp_p1) ? w_lz_ext : r_exp_p1;

        w_pay_p1.data   = r_data_p1 << w_sh;
        w_pay_p1.exp    = sat_exp_sub(r_exp_p1, w_lz_ext);
        w_pay_p1.zero   = 1'b0;
        w_pay_p1.denorm = (w_lz_ext > r_exp_p1);

        if (r_data_p1 == '0) begin
            w_pay_p1.data   = '0;
            w_pay_p1.exp    = '0;
            w_pay_p1.zero   = 1'b1;
            w_pay_p1.denorm = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_adv2) begin
            r_pay_p2 <= w_pay_p1;
        end
    end

    // S2 -> outputs: fields read as zero whenever nothing valid is held
    assign v_o      = r_vld_p2;
    assign data_o   = r_vld_p2 ? r_pay_p2.data   : '0;
    assign exp_o    = r_vld_p2 ? r_pay_p2.exp    : '0;
    assign zero_o   = r_vld_p2 ? r_pay_p2.zero   : 1'b0;
    assign denorm_o = r_vld_p2 ? r_pay_p2.denorm : 1'b0;

    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> r_vld_p2
    );

endmodule

// File: tb/tb_bsg_normalize_shift_pipe.sv
// Directed bench for the normalize-shift pipeline with an in-order scoreboard.
module tb_bsg_normalize_shift_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        v_i = 1'b0;
    logic        ready_o;
    logic [15:0] data_i = '0;
    logic [7:0]  exp_i = '0;
    logic        v_o;
    logic        yumi_en = 1'b0;
    wire         yumi = yumi_en & v_o;
    logic [15:0] data_o;
    logic [7:0]  exp_o;
    logic        zero_o;
    logic        denorm_o;

    always #5 clk = ~clk;

    bsg_normalize_shift_pipe #(.width_p(16), .exp_width_p(8)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .exp_i     (exp_i),
        .v_o       (v_o),
        .yumi_i    (yumi),
        .data_o    (data_o),
        .exp_o     (exp_o),
        .zero_o    (zero_o),
        .denorm_o  (denorm_o)
    );

    // Hand-computed vectors: inputs and expected normalized outputs.
    logic [15:0] v_din  [10] = '{16'h0001, 16'h8000, 16'h0000, 16'h0010, 16'h00FF,
                                 16'h0003, 16'hFFFF, 16'h0000, 16'h1234, 16'h0001};
    logic [7:0]  v_ein  [10] = '{8'd20, 8'd3, 8'd9, 8'd4, 8'd8, 8'd0, 8'd255, 8'd0, 8'd10, 8'd15};
    logic [15:0] v_dout [10] = '{16'h8000, 16'h8000, 16'h0000, 16'h0100, 16'hFF00,
                                 16'h0003, 16'hFFFF, 16'h0000, 16'h91A0, 16'h8000};
    logic [7:0]  v_eout [10] = '{8'd5, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd7, 8'd0};
    logic        v_z    [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        v_dn   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    int          total = 0;
    int          bad = 0;
    int          n_in = 0;
    int          n_out = 0;
    logic        last_fire = 1'b0;
    logic [25:0] cur_exp = '0;
    logic [25:0] expq[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic drive(input int i);
        v_i     = 1'b1;
        data_i  = v_din[i];
        exp_i   = v_ein[i];
        cur_exp = {v_dout[i], v_eout[i], v_z[i], v_dn[i]};
    endtask

    // One clock: sample handshakes just before the edge, then realign to negedge.
    task automatic tick();
        logic [25:0] w;
        #1;
        last_fire = v_i & ready_o;
        if (last_fire) begin
            expq.push_back(cur_exp);
            n_in++;
        end
        if (v_o && yumi) begin
            check_val("out_has_expect", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                w = expq.pop_front();
                check_val("out_payload", 32'({data_o, exp_o, zero_o, denorm_o}), 32'(w));
            end
            n_out++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;

        #1 reset_n = 1'b0;
        #2;
        check_val("rst_vo", 32'(v_o), 32'd0);
        check_val("rst_ready", 32'(ready_o), 32'd1);
        check_val("rst_data", 32'(data_o), 32'd0);
        check_val("rst_flags", 32'({exp_o, zero_o, denorm_o}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single item latency
        yumi_en = 1'b1;
        drive(0);
        tick();
        v_i = 1'b0;
        check_val("lat1_vo", 32'(v_o), 32'd0);
        tick();
        check_val("lat2_vo", 32'(v_o), 32'd1);
        check_val("lat2_data", 32'(data_o), 32'h8000);
        check_val("lat2_exp", 32'(exp_o), 32'd5);
        tick();
        check_val("lat_done", 32'(n_out), 32'd1);

        // Back-to-back stream of the remaining vectors
        n_in = 0;
        n_out = 0;
        for (int i = 1; i < 10; i++) begin
            drive(i);
            tick();
        end
        v_i = 1'b0;
        check_val("stream_full_rate", 32'(n_in), 32'd9);
        for (int c = 0; c < 10 && n_out < 9; c++) tick();
        check_val("stream_out_cnt", 32'(n_out), 32'd9);
        check_val("stream_drained", 32'(expq.size()), 32'd0);

        // Stall with S1 and S2 full
        n_in = 0;
        n_out = 0;
        idx = 0;
        yumi_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(idx);
            tick();
            if (last_fire) idx++;
        end
        #1;
        check_val("stall_ready", 32'(ready_o), 32'd0);
        check_val("stall_vo", 32'(v_o), 32'd1);
        check_val("stall_hold", 32'(data_o), 32'(v_dout[0]));
        check_val("stall_n_in", 32'(n_in), 32'd2);
        yumi_en = 1'b1;
        cyc = 0;
        for (int c = 0; c < 20 && n_out < 5; c++) begin
            if (idx < 5) drive(idx);
            else v_i = 1'b0;
            tick();
            if (last_fire) idx++;
            cyc++;
        end
        v_i = 1'b0;
        check_val("stall_out_cnt", 32'(n_out), 32'd5);
        check_val("stall_out_cycles", 32'(cyc), 32'd5);
        check_val("stall_drained", 32'(expq.size()), 32'd0);

        // Reset with two items in flight
        yumi_en = 1'b0;
        drive(1);
        tick();
        drive(2);
        tick();
        v_i = 1'b0;
        check_val("pre_rst_vo", 32'(v_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("mid_rst_vo", 32'(v_o), 32'd0);
        check_val("mid_rst_data", 32'(data_o), 32'd0);
        check_val("mid_rst_ready", 32'(ready_o), 32'd1);
        expq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_vo", 32'(v_o), 32'd0);
        check_val("post_rst_ready", 32'(ready_o), 32'd1);
        yumi_en = 1'b1;
        n_out = 0;
        drive(3);
        tick();
        v_i = 1'b0;
        check_val("post_rst_lat1", 32'(v_o), 32'd0);
        tick();
        check_val("post_rst_lat2", 32'(v_o), 32'd1);
        check_val("post_rst_denorm", 32'({data_o, denorm_o}), 32'({16'h0100, 1'b1}));
        tick();
        check_val("post_rst_out_cnt", 32'(n_out), 32'd1);
        check_val("post_rst_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
